// File: rtl/inst_fetcher_pkg.sv
// Shared types for the instruction fetch front-end: instruction/register words,
// fetcher FSM states and the instruction-queue entry layout.
package inst_fetcher_pkg;

    localparam int XLEN              = 32;
    localparam int IQ_ADDR_WIDTH_DEF = 4;

    typedef logic [XLEN-1:0] inst_t;
    typedef logic [XLEN-1:0] reg_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        inst_t inst;
        reg_t  pc;
        reg_t  pred_pc;
    } iq_entry_t;

endpackage

// File: rtl/inst_fetcher_if.sv
// Bus bundle around the fetcher: icache request/response, branch predictor,
// issuer-side queue head and the ROB redirect bus.
interface inst_fetcher_if;
    import inst_fetcher_pkg::*;

    logic  valid_to_icache;
    reg_t  pc_to_icache;
    logic  valid_from_icache;
    inst_t inst_from_icache;

    inst_t inst_to_br_predictor;
    reg_t  pc_to_br_predictor;
    reg_t  next_pc_from_br_predictor;

    logic  valid_to_issuer;
    inst_t inst_to_issuer;
    reg_t  pc_to_issuer;
    reg_t  pred_pc_to_issuer;
    logic  ready_from_issuer;

    logic  reset_valid_from_rob_bus;
    reg_t  reset_pc_from_rob_bus;

    modport master (
        output valid_to_icache, pc_to_icache,
        input  valid_from_icache, inst_from_icache,
        output inst_to_br_predictor, pc_to_br_predictor,
        input  next_pc_from_br_predictor,
        output valid_to_issuer, inst_to_issuer, pc_to_issuer, pred_pc_to_issuer,
        input  ready_from_issuer,
        input  reset_valid_from_rob_bus, reset_pc_from_rob_bus
    );

    modport slave (
        input  valid_to_icache, pc_to_icache,
        output valid_from_icache, inst_from_icache,
        input  inst_to_br_predictor, pc_to_br_predictor,
        output next_pc_from_br_predictor,
        input  valid_to_issuer, inst_to_issuer, pc_to_issuer, pred_pc_to_issuer,
        output ready_from_issuer,
        output reset_valid_from_rob_bus, reset_pc_from_rob_bus
    );

endinterface

// File: rtl/inst_fetcher_inst_queue.sv
// Show-ahead FIFO of {inst, pc, pred_pc}; head is readable while non-empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module inst_fetcher_inst_queue
    import inst_fetcher_pkg::*;
#(
    parameter int ADDR_WIDTH = IQ_ADDR_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  iq_entry_t           push_entry,
    input  logic                pop,
    input  logic                clear,
    output iq_entry_t           head_entry,
    output logic                empty,
    output logic [ADDR_WIDTH:0] count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    iq_entry_t             mem [DEPTH];
    logic [ADDR_WIDTH:0]   head_ptr;
    logic [ADDR_WIDTH:0]   tail_ptr;
    logic                  full;
    logic                  do_pop;
    logic                  do_push;

    assign empty = (head_ptr == tail_ptr);
    assign full  = (head_ptr[ADDR_WIDTH] != tail_ptr[ADDR_WIDTH]) &&
                   (head_ptr[ADDR_WIDTH-1:0] == tail_ptr[ADDR_WIDTH-1:0]);
    assign count = tail_ptr - head_ptr;

    // A push into a full queue is only accepted when the head leaves the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head_entry = mem[head_ptr[ADDR_WIDTH-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
        end else if (clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
        end else begin
            if (do_pop)  head_ptr <= head_ptr + 1'b1;
            if (do_push) tail_ptr <= tail_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[tail_ptr[ADDR_WIDTH-1:0]] <= push_entry;
        end
    end

endmodule

// File: rtl/inst_fetcher.sv
// Fetch stage: one outstanding icache request at a time, predictor-driven PC,
// fetched instructions buffered for the issuer; ROB flush redirects and drains.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int   IQ_ADDR_WIDTH = IQ_ADDR_WIDTH_DEF,
    parameter reg_t RESET_PC      = 32'h0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy,
    inst_fetcher_if.master bus
);

    localparam logic [IQ_ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {IQ_ADDR_WIDTH{1'b0}}};

    fetch_state_e           state, state_next;
    reg_t                   pc, pc_next;
    reg_t                   req_pc, req_pc_next;

    logic                   iq_push;
    logic                   iq_pop;
    logic                   iq_clear;
    iq_entry_t              iq_push_entry;
    iq_entry_t              iq_head;
    logic                   iq_empty;
    logic [IQ_ADDR_WIDTH:0] iq_count;

    logic                   flush;
    logic                   resp;

    assign flush = bus.reset_valid_from_rob_bus;
    assign resp  = bus.valid_from_icache;

    assign iq_push_entry = '{inst:    bus.inst_from_icache,
                             pc:      pc,
                             pred_pc: bus.next_pc_from_br_predictor};

    // NOTE: every signal driven here gets a default first, so no path leaves a latch.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        req_pc_next = req_pc;
        iq_push     = 1'b0;
        iq_pop      = 1'b0;
        iq_clear    = 1'b0;

        if (rdy) begin
            iq_pop = bus.ready_from_issuer && !iq_empty;

            unique case (state)
                ST_IDLE: begin
                    if (flush) begin
                        pc_next = bus.reset_pc_from_rob_bus;
                    end else if (iq_count < DEPTH_CNT) begin
                        state_next  = ST_REQ;
                        req_pc_next = pc;
                    end
                end
                ST_REQ: begin
                    if (flush) begin
                        pc_next = bus.reset_pc_from_rob_bus;
                        // A same-cycle response retires the request, so nothing is left to drop.
                        state_next = resp ? ST_IDLE : ST_DROP;
                    end else if (resp) begin
                        iq_push    = 1'b1;
                        pc_next    = bus.next_pc_from_br_predictor;
                        state_next = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (flush) pc_next = bus.reset_pc_from_rob_bus;
                    if (resp)  state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase

            if (flush) begin
                iq_clear = 1'b1;
                iq_pop   = 1'b0;
                iq_push  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            req_pc <= req_pc_next;
        end
    end

    inst_fetcher_inst_queue #(
        .ADDR_WIDTH (IQ_ADDR_WIDTH)
    ) u_inst_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (iq_push),
        .push_entry (iq_push_entry),
        .pop        (iq_pop),
        .clear      (iq_clear),
        .head_entry (iq_head),
        .empty      (iq_empty),
        .count      (iq_count)
    );

    // The request address is latched at issue so a redirect cannot disturb it mid-flight.
    assign bus.valid_to_icache      = (state != ST_IDLE);
    assign bus.pc_to_icache         = req_pc;
    assign bus.inst_to_br_predictor = bus.inst_from_icache;
    assign bus.pc_to_br_predictor   = pc;

    assign bus.valid_to_issuer   = !iq_empty;
    assign bus.inst_to_issuer    = iq_head.inst;
    assign bus.pc_to_issuer      = iq_head.pc;
    assign bus.pred_pc_to_issuer = iq_head.pred_pc;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: the bench plays icache, predictor, issuer
// and ROB, and compares every observed output with hand-computed values.
module tb_inst_fetcher;
    import inst_fetcher_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    inst_fetcher_if bus ();

    inst_fetcher #(
        .IQ_ADDR_WIDTH (4),
        .RESET_PC      (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus.master)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.valid_from_icache         = 1'b0;
        bus.inst_from_icache          = '0;
        bus.next_pc_from_br_predictor = '0;
        bus.ready_from_issuer         = 1'b0;
        bus.reset_valid_from_rob_bus  = 1'b0;
        bus.reset_pc_from_rob_bus     = '0;
    endtask

    // Bounded wait for a pending icache request; an expired bound is a failure.
    task automatic wait_req(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.valid_to_icache === 1'b1) ok = 1'b1;
            else step();
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: valid_to_icache got 0 want 1 within 20 cycles", tag);
        end
    endtask

    task automatic respond(input inst_t inst, input reg_t npc);
        bus.valid_from_icache         = 1'b1;
        bus.inst_from_icache          = inst;
        bus.next_pc_from_br_predictor = npc;
        step();
        bus.valid_from_icache = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rdy = 1'b1;
        idle_inputs();
        step();
        step();
        total++; if (bus.valid_to_icache !== 1'b0) begin bad++; $display("FAIL reset_vic: got %b want 0", bus.valid_to_icache); end
        total++; if (bus.valid_to_issuer !== 1'b0) begin bad++; $display("FAIL reset_vis: got %b want 0", bus.valid_to_issuer); end
        total++; if (bus.pc_to_br_predictor !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", bus.pc_to_br_predictor); end
        rst = 1'b1;
        step();
        total++; if ({bus.valid_to_icache, bus.pc_to_icache} !== {1'b1, 32'h0}) begin bad++; $display("FAIL reset_first_req: got %b/%h want 1/0", bus.valid_to_icache, bus.pc_to_icache); end
        rst = 1'b0;
        #1;
        total++; if (bus.valid_to_icache !== 1'b0) begin bad++; $display("FAIL reset_async_vic: got %b want 0", bus.valid_to_icache); end
        total++; if (bus.valid_to_issuer !== 1'b0) begin bad++; $display("FAIL reset_async_vis: got %b want 0", bus.valid_to_issuer); end
        step();
        rst = 1'b1;
        step();
        total++; if ({bus.valid_to_icache, bus.pc_to_icache} !== {1'b1, 32'h0}) begin bad++; $display("FAIL reset_rerelease_req: got %b/%h want 1/0", bus.valid_to_icache, bus.pc_to_icache); end
    endtask

    task automatic test_straight_line();
        reg_t  pcs   [3] = '{32'h0, 32'h4, 32'h8};
        inst_t insts [3] = '{32'h0000_0013, 32'h0040_0093, 32'h0080_0113};
        reg_t  preds [3] = '{32'h4, 32'h8, 32'hC};
        for (int i = 0; i < 3; i++) begin
            wait_req("straight_wait");
            total++; if (bus.pc_to_icache !== pcs[i]) begin bad++; $display("FAIL straight_req_pc%0d: got %h want %h", i, bus.pc_to_icache, pcs[i]); end
            total++; if (bus.pc_to_br_predictor !== pcs[i]) begin bad++; $display("FAIL straight_bp_pc%0d: got %h want %h", i, bus.pc_to_br_predictor, pcs[i]); end
            if (i == 0) begin
                total++; if (bus.valid_to_issuer !== 1'b0) begin bad++; $display("FAIL straight_pre_empty: got %b want 0", bus.valid_to_issuer); end
            end
            bus.valid_from_icache         = 1'b1;
            bus.inst_from_icache          = insts[i];
            bus.next_pc_from_br_predictor = preds[i];
            #1;
            total++; if (bus.inst_to_br_predictor !== insts[i]) begin bad++; $display("FAIL straight_bp_inst%0d: got %h want %h", i, bus.inst_to_br_predictor, insts[i]); end
            step();
            bus.valid_from_icache = 1'b0;
            total++; if ({bus.valid_to_issuer, bus.valid_to_icache} !== 2'b10) begin bad++; $display("FAIL straight_after_resp%0d: vis/vic got %b want 10", i, {bus.valid_to_issuer, bus.valid_to_icache}); end
        end
        bus.ready_from_issuer = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({bus.valid_to_issuer, bus.inst_to_issuer, bus.pc_to_issuer, bus.pred_pc_to_issuer} !== {1'b1, insts[i], pcs[i], preds[i]}) begin
                bad++;
                $display("FAIL straight_head%0d: got v=%b inst=%h pc=%h pred=%h want v=1 inst=%h pc=%h pred=%h", i,
                         bus.valid_to_issuer, bus.inst_to_issuer, bus.pc_to_issuer, bus.pred_pc_to_issuer, insts[i], pcs[i], preds[i]);
            end
            step();
        end
        bus.ready_from_issuer = 1'b0;
        total++; if (bus.valid_to_issuer !== 1'b0) begin bad++; $display("FAIL straight_drained: got %b want 0", bus.valid_to_issuer); end
    endtask

    task automatic test_taken_branch();
        wait_req("taken_wait0");
        total++; if (bus.pc_to_icache !== 32'hC) begin bad++; $display("FAIL taken_req_c: got %h want c", bus.pc_to_icache); end
        respond(32'h0000_0463, 32'h10);
        wait_req("taken_wait1");
        total++; if (bus.pc_to_icache !== 32'h10) begin bad++; $display("FAIL taken_req_10: got %h want 10", bus.pc_to_icache); end
        respond(32'h0F00_006F, 32'h100);
        wait_req("taken_wait2");
        total++; if (bus.pc_to_icache !== 32'h100) begin bad++; $display("FAIL taken_target: got %h want 100", bus.pc_to_icache); end
        total++; if ({bus.pc_to_issuer, bus.pred_pc_to_issuer} !== {32'hC, 32'h10}) begin bad++; $display("FAIL taken_head0: got pc=%h pred=%h want c/10", bus.pc_to_issuer, bus.pred_pc_to_issuer); end
        bus.ready_from_issuer = 1'b1;
        step();
        total++;
        if ({bus.valid_to_issuer, bus.inst_to_issuer, bus.pc_to_issuer, bus.pred_pc_to_issuer} !== {1'b1, 32'h0F00_006F, 32'h10, 32'h100}) begin
            bad++;
            $display("FAIL taken_head1: got v=%b inst=%h pc=%h pred=%h want 1/0f00006f/10/100", bus.valid_to_issuer, bus.inst_to_issuer, bus.pc_to_issuer, bus.pred_pc_to_issuer);
        end
        step();
        bus.ready_from_issuer = 1'b0;
        total++; if (bus.valid_to_issuer !== 1'b0) begin bad++; $display("FAIL taken_drained: got %b want 0", bus.valid_to_issuer); end
    endtask

    task automatic test_full();
        reg_t  exp_pc;
        inst_t exp_inst;
        bus.ready_from_issuer = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_pc = 32'h100 + 32'(4 * i);
            wait_req("full_wait");
            total++; if (bus.pc_to_icache !== exp_pc) begin bad++; $display("FAIL full_req%0d: got %h want %h", i, bus.pc_to_icache, exp_pc); end
            respond(32'h1000 + 32'(i), exp_pc + 32'h4);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (bus.valid_to_icache !== 1'b0) begin bad++; $display("FAIL full_gate%0d: valid_to_icache got %b want 0", i, bus.valid_to_icache); end
        end
        total++; if ({bus.valid_to_issuer, bus.pc_to_issuer} !== {1'b1, 32'h100}) begin bad++; $display("FAIL full_head: got %b/%h want 1/100", bus.valid_to_issuer, bus.pc_to_issuer); end
        bus.ready_from_issuer = 1'b1;
        step();
        bus.ready_from_issuer = 1'b0;
        total++; if (bus.valid_to_icache !== 1'b0) begin bad++; $display("FAIL full_pop_edge: valid_to_icache got %b want 0", bus.valid_to_icache); end
        step();
        total++; if ({bus.valid_to_icache, bus.pc_to_icache} !== {1'b1, 32'h140}) begin bad++; $display("FAIL full_rerequest: got %b/%h want 1/140", bus.valid_to_icache, bus.pc_to_icache); end
        respond(32'h2000, 32'h144);
        bus.ready_from_issuer = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_pc   = 32'h104 + 32'(4 * i);
            exp_inst = (i < 15) ? 32'h1001 + 32'(i) : 32'h2000;
            total++;
            if ({bus.valid_to_issuer, bus.inst_to_issuer, bus.pc_to_issuer, bus.pred_pc_to_issuer} !== {1'b1, exp_inst, exp_pc, exp_pc + 32'h4}) begin
                bad++;
                $display("FAIL full_drain%0d: got v=%b inst=%h pc=%h pred=%h want inst=%h pc=%h", i,
                         bus.valid_to_issuer, bus.inst_to_issuer, bus.pc_to_issuer, bus.pred_pc_to_issuer, exp_inst, exp_pc);
            end
            step();
        end
        bus.ready_from_issuer = 1'b0;
        total++; if (bus.valid_to_issuer !== 1'b0) begin bad++; $display("FAIL full_empty: got %b want 0", bus.valid_to_issuer); end
    endtask

    task automatic test_flush_req();
        wait_req("flush_wait0");
        total++; if (bus.pc_to_icache !== 32'h144) begin bad++; $display("FAIL flush_req144: got %h want 144", bus.pc_to_icache); end
        respond(32'h3000, 32'h148);
        wait_req("flush_wait1");
        total++; if ({bus.valid_to_issuer, bus.pc_to_icache} !== {1'b1, 32'h148}) begin bad++; $display("FAIL flush_pre: got %b/%h want 1/148", bus.valid_to_issuer, bus.pc_to_icache); end
        bus.reset_valid_from_rob_bus = 1'b1;
        bus.reset_pc_from_rob_bus    = 32'h200;
        step();
        bus.reset_valid_from_rob_bus = 1'b0;
        total++; if (bus.valid_to_issuer !== 1'b0) begin bad++; $display("FAIL flush_emptied: got %b want 0", bus.valid_to_issuer); end
        total++; if ({bus.valid_to_icache, bus.pc_to_icache} !== {1'b1, 32'h148}) begin bad++; $display("FAIL flush_req_held: got %b/%h want 1/148", bus.valid_to_icache, bus.pc_to_icache); end
        total++; if (bus.pc_to_br_predictor !== 32'h200) begin bad++; $display("FAIL flush_pc: got %h want 200", bus.pc_to_br_predictor); end
        step();
        respond(32'hDEAD_BEEF, 32'h999);
        total++; if ({bus.valid_to_issuer, bus.valid_to_icache} !== 2'b00) begin bad++; $display("FAIL flush_dropped: vis/vic got %b want 00", {bus.valid_to_issuer, bus.valid_to_icache}); end
        total++; if (bus.pc_to_br_predictor !== 32'h200) begin bad++; $display("FAIL flush_pc_kept: got %h want 200", bus.pc_to_br_predictor); end
        step();
        total++; if ({bus.valid_to_icache, bus.pc_to_icache} !== {1'b1, 32'h200}) begin bad++; $display("FAIL flush_redirect_req: got %b/%h want 1/200", bus.valid_to_icache, bus.pc_to_icache); end
    endtask

    task automatic test_flush_resp_pop();
        wait_req("frp_wait0");
        respond(32'h4000, 32'h204);
        wait_req("frp_wait1");
        total++; if ({bus.valid_to_issuer, bus.pc_to_icache} !== {1'b1, 32'h204}) begin bad++; $display("FAIL frp_pre: got %b/%h want 1/204", bus.valid_to_issuer, bus.pc_to_icache); end
        bus.valid_from_icache         = 1'b1;
        bus.inst_from_icache          = 32'h4444;
        bus.next_pc_from_br_predictor = 32'h208;
        bus.ready_from_issuer         = 1'b1;
        bus.reset_valid_from_rob_bus  = 1'b1;
        bus.reset_pc_from_rob_bus     = 32'h300;
        step();
        idle_inputs();
        total++; if (bus.valid_to_issuer !== 1'b0) begin bad++; $display("FAIL frp_no_push: got %b want 0", bus.valid_to_issuer); end
        total++; if (bus.pc_to_br_predictor !== 32'h300) begin bad++; $display("FAIL frp_pc: got %h want 300", bus.pc_to_br_predictor); end
        step();
        total++; if ({bus.valid_to_icache, bus.pc_to_icache} !== {1'b1, 32'h300}) begin bad++; $display("FAIL frp_req: got %b/%h want 1/300", bus.valid_to_icache, bus.pc_to_icache); end
    endtask

    task automatic test_rdy_freeze();
        respond(32'h5000, 32'h304);
        wait_req("rdy_wait");
        rdy = 1'b0;
        bus.valid_from_icache         = 1'b1;
        bus.inst_from_icache          = 32'h5555;
        bus.next_pc_from_br_predictor = 32'h999;
        bus.ready_from_issuer         = 1'b1;
        bus.reset_valid_from_rob_bus  = 1'b1;
        bus.reset_pc_from_rob_bus     = 32'h400;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({bus.valid_to_icache, bus.pc_to_icache, bus.pc_to_br_predictor, bus.valid_to_issuer, bus.pc_to_issuer} !==
                {1'b1, 32'h304, 32'h304, 1'b1, 32'h300}) begin
                bad++;
                $display("FAIL rdy_freeze%0d: got vic=%b req=%h pc=%h vis=%b head=%h want 1/304/304/1/300", i,
                         bus.valid_to_icache, bus.pc_to_icache, bus.pc_to_br_predictor, bus.valid_to_issuer, bus.pc_to_issuer);
            end
        end
        idle_inputs();
        rdy = 1'b1;
        step();
        total++; if ({bus.valid_to_icache, bus.pc_to_icache, bus.pc_to_issuer} !== {1'b1, 32'h304, 32'h300}) begin bad++; $display("FAIL rdy_resume: got %b/%h/%h want 1/304/300", bus.valid_to_icache, bus.pc_to_icache, bus.pc_to_issuer); end
    endtask

    task automatic test_back_to_back();
        bus.valid_from_icache         = 1'b1;
        bus.inst_from_icache          = 32'h6000;
        bus.next_pc_from_br_predictor = 32'h308;
        bus.ready_from_issuer         = 1'b1;
        step();
        idle_inputs();
        total++;
        if ({bus.valid_to_issuer, bus.inst_to_issuer, bus.pc_to_issuer, bus.pred_pc_to_issuer} !== {1'b1, 32'h6000, 32'h304, 32'h308}) begin
            bad++;
            $display("FAIL b2b_pushpop: got v=%b inst=%h pc=%h pred=%h want 1/6000/304/308", bus.valid_to_issuer, bus.inst_to_issuer, bus.pc_to_issuer, bus.pred_pc_to_issuer);
        end
        bus.ready_from_issuer = 1'b1;
        step();
        bus.ready_from_issuer = 1'b0;
        total++; if (bus.valid_to_issuer !== 1'b0) begin bad++; $display("FAIL b2b_single_left: got %b want 0", bus.valid_to_issuer); end
        wait_req("b2b_wait");
        total++; if (bus.pc_to_icache !== 32'h308) begin bad++; $display("FAIL b2b_req: got %h want 308", bus.pc_to_icache); end
        bus.valid_from_icache         = 1'b1;
        bus.inst_from_icache          = 32'h7000;
        bus.next_pc_from_br_predictor = 32'h30C;
        bus.ready_from_issuer         = 1'b1;
        #1;
        total++; if (bus.valid_to_issuer !== 1'b0) begin bad++; $display("FAIL b2b_no_bypass: got %b want 0", bus.valid_to_issuer); end
        step();
        idle_inputs();
        total++; if ({bus.valid_to_issuer, bus.pc_to_issuer, bus.inst_to_issuer} !== {1'b1, 32'h308, 32'h7000}) begin bad++; $display("FAIL b2b_empty_push: got %b/%h/%h want 1/308/7000", bus.valid_to_issuer, bus.pc_to_issuer, bus.inst_to_issuer); end
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_taken_branch();
        test_full();
        test_flush_req();
        test_flush_resp_pop();
        test_rdy_freeze();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
